// File: rtl/btb_ctrl_pkg.sv
// Shared definitions for the BTB update controller: opcode constant, FSM
// state encoding and the kind of BTB correction a resolved branch needs.
package btb_ctrl_pkg;

  localparam logic [6:0] BR_OP = 7'b110_0011;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } ctrl_state_e;

  typedef enum logic [1:0] {
    MP_NONE,
    MP_RETARGET,
    MP_NOTTAKEN,
    MP_ALLOC
  } mp_kind_e;

  function automatic logic is_branch_op(input logic [6:0] opcode);
    return opcode == BR_OP;
  endfunction

endpackage

// File: rtl/btb_mp_classify.sv
// Combinational decode of a resolving branch: what went wrong with the IF
// prediction, whether to flush, and where fetch must restart.
module btb_mp_classify
  import btb_ctrl_pkg::*;
(
  input  logic        resolve,
  input  logic        predicted,
  input  logic        taken,
  input  logic [31:0] pc,
  input  logic [31:0] actual_target,
  input  logic [31:0] pred_target,
  output mp_kind_e    kind,
  output logic        mispredict,
  output logic [31:0] redirect_pc
);

  always_comb begin
    kind        = MP_NONE;
    mispredict  = 1'b0;
    redirect_pc = 32'h0;
    if (resolve) begin
      if (predicted) begin
        if (!taken) begin
          kind        = MP_NOTTAKEN;
          mispredict  = 1'b1;
          redirect_pc = pc + 32'd4;
        end else if (pred_target != actual_target) begin
          kind        = MP_RETARGET;
          mispredict  = 1'b1;
          redirect_pc = actual_target;
        end
      end else if (taken) begin
        kind        = MP_ALLOC;
        mispredict  = 1'b1;
        redirect_pc = actual_target;
      end
    end
  end

endmodule

// File: rtl/btb_ctrl.sv
// BTB update controller: invalidation sweep FSM, single registered BTB write
// port, round-robin victim allocation and branch/mispredict statistics.
module btb_ctrl
  import btb_ctrl_pkg::*;
#(
  parameter int  ENTRY_NUM = 64,
  localparam int IDX_W     = $clog2(ENTRY_NUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InvalidateAll,
  input  logic             EnE,
  input  logic             IsBranchE,
  input  logic [31:0]      PCE,
  input  logic             BranchE,
  input  logic [31:0]      BrNPC,
  input  logic             PredictedE,
  input  logic [31:0]      PredPCE,
  input  logic [IDX_W-1:0] HitIdxE,
  output logic             MispredictE,
  output logic [31:0]      RedirectPC,
  output logic             BtbWe,
  output logic [IDX_W-1:0] BtbWIdx,
  output logic [31:0]      BtbWTag,
  output logic [31:0]      BtbWTarget,
  output logic             BtbWValid,
  output logic             Ready,
  output logic [31:0]      BranchCnt,
  output logic [31:0]      MissCnt
);

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRY_NUM - 1);

  ctrl_state_e      state;
  logic [IDX_W-1:0] sweep_idx;
  logic [IDX_W-1:0] victim;
  mp_kind_e         kind;
  logic             resolve;

  assign resolve = EnE & IsBranchE;

  btb_mp_classify u_classify (
    .resolve       (resolve),
    .predicted     (PredictedE),
    .taken         (BranchE),
    .pc            (PCE),
    .actual_target (BrNPC),
    .pred_target   (PredPCE),
    .kind          (kind),
    .mispredict    (MispredictE),
    .redirect_pc   (RedirectPC)
  );

  // BtbWe is a one-cycle strobe with the other BtbW* fields valid alongside
  // it; the BTB has no ready and must accept every strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_INIT;
      sweep_idx  <= '0;
      victim     <= '0;
      BtbWe      <= 1'b0;
      BtbWIdx    <= '0;
      BtbWTag    <= 32'h0;
      BtbWTarget <= 32'h0;
      BtbWValid  <= 1'b0;
      Ready      <= 1'b0;
      BranchCnt  <= 32'h0;
      MissCnt    <= 32'h0;
    end else begin
      if (resolve) begin
        BranchCnt <= BranchCnt + 32'd1;
        if (MispredictE) MissCnt <= MissCnt + 32'd1;
      end
      case (state)
        ST_INIT: begin
          BtbWe      <= 1'b1;
          BtbWIdx    <= sweep_idx;
          BtbWTag    <= 32'h0;
          BtbWTarget <= 32'h0;
          BtbWValid  <= 1'b0;
          Ready      <= 1'b0;
          sweep_idx  <= sweep_idx + IDX_ONE;
          if (sweep_idx == IDX_LAST) state <= ST_RUN;
        end
        ST_RUN: begin
          Ready <= 1'b1;
          BtbWe <= 1'b0;
          if (InvalidateAll) begin
            state     <= ST_INIT;
            sweep_idx <= '0;
            Ready     <= 1'b0;
          end else begin
            case (kind)
              MP_RETARGET: begin
                BtbWe      <= 1'b1;
                BtbWIdx    <= HitIdxE;
                BtbWTag    <= PCE;
                BtbWTarget <= BrNPC;
                BtbWValid  <= 1'b1;
              end
              MP_NOTTAKEN: begin
                BtbWe      <= 1'b1;
                BtbWIdx    <= HitIdxE;
                BtbWTag    <= PCE;
                BtbWTarget <= RedirectPC;
                BtbWValid  <= 1'b0;
              end
              MP_ALLOC: begin
                BtbWe      <= 1'b1;
                BtbWIdx    <= victim;
                BtbWTag    <= PCE;
                BtbWTarget <= BrNPC;
                BtbWValid  <= 1'b1;
                victim     <= victim + IDX_ONE;
              end
              default: ;
            endcase
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_btb_ctrl.sv
// Randomised bench for btb_ctrl against a rule-level model of flush,
// BTB writes, victim allocation and counters.
module tb_btb_ctrl;
  import btb_ctrl_pkg::*;

  localparam int ENTRY_NUM = 4;
  localparam int IDX_W     = $clog2(ENTRY_NUM);
  localparam int WR_W      = IDX_W + 65;

  logic             clk;
  logic             rst;
  logic             InvalidateAll;
  logic             EnE;
  logic             IsBranchE;
  logic [31:0]      PCE;
  logic             BranchE;
  logic [31:0]      BrNPC;
  logic             PredictedE;
  logic [31:0]      PredPCE;
  logic [IDX_W-1:0] HitIdxE;
  logic             MispredictE;
  logic [31:0]      RedirectPC;
  logic             BtbWe;
  logic [IDX_W-1:0] BtbWIdx;
  logic [31:0]      BtbWTag;
  logic [31:0]      BtbWTarget;
  logic             BtbWValid;
  logic             Ready;
  logic [31:0]      BranchCnt;
  logic [31:0]      MissCnt;

  btb_ctrl #(.ENTRY_NUM(ENTRY_NUM)) dut (
    .clk           (clk),
    .rst           (rst),
    .InvalidateAll (InvalidateAll),
    .EnE           (EnE),
    .IsBranchE     (IsBranchE),
    .PCE           (PCE),
    .BranchE       (BranchE),
    .BrNPC         (BrNPC),
    .PredictedE    (PredictedE),
    .PredPCE       (PredPCE),
    .HitIdxE       (HitIdxE),
    .MispredictE   (MispredictE),
    .RedirectPC    (RedirectPC),
    .BtbWe         (BtbWe),
    .BtbWIdx       (BtbWIdx),
    .BtbWTag       (BtbWTag),
    .BtbWTarget    (BtbWTarget),
    .BtbWValid     (BtbWValid),
    .Ready         (Ready),
    .BranchCnt     (BranchCnt),
    .MissCnt       (MissCnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state and scoreboard
  int              checks = 0;
  int              passes = 0;
  logic [31:0]     m_branch = 0;
  logic [31:0]     m_miss = 0;
  int              m_victim = 0;
  bit              m_run = 0;
  logic            exp_mp;
  logic            exp_res;
  logic [31:0]     exp_rd;
  logic [WR_W-1:0] exp_q[$];
  logic [WR_W-1:0] w;

  // driver: present one EX-stage cycle and update the model
  task automatic apply_branch(input logic en, input logic [6:0] opcode, input logic [31:0] pc,
                              input logic pred, input logic taken, input logic [31:0] npc,
                              input logic [31:0] ppc, input logic [IDX_W-1:0] hidx,
                              input logic inval);
    @(negedge clk);
    EnE = en; IsBranchE = is_branch_op(opcode); PCE = pc; PredictedE = pred;
    BranchE = taken; BrNPC = npc; PredPCE = ppc; HitIdxE = hidx; InvalidateAll = inval;
    exp_res = en && is_branch_op(opcode);
    if (!exp_res)                 exp_mp = 1'b0;
    else if (pred && !taken)      exp_mp = 1'b1;
    else if (pred)                exp_mp = (ppc != npc);
    else                          exp_mp = taken;
    exp_rd = !exp_mp ? 32'h0 : ((pred && !taken) ? pc + 32'd4 : npc);
    if (exp_res) begin
      m_branch = m_branch + 1;
      if (exp_mp) m_miss = m_miss + 1;
    end
    if (m_run && !inval && exp_mp) begin
      if (pred) exp_q.push_back({hidx, pc, npc, taken});
      else begin
        exp_q.push_back({IDX_W'(m_victim), pc, npc, 1'b1});
        m_victim = (m_victim + 1) % ENTRY_NUM;
      end
    end
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    EnE = 0; IsBranchE = 0; InvalidateAll = 0; PredictedE = 0; BranchE = 0;
  endtask

  task automatic test_reset();
    rst = 1; InvalidateAll = 0; EnE = 0; IsBranchE = 0; PCE = 0; BranchE = 0;
    BrNPC = 0; PredictedE = 0; PredPCE = 0; HitIdxE = 0;
    #3;
    checks++;
    if ({BtbWe, BtbWValid, Ready, BtbWIdx, BtbWTag, BtbWTarget, BranchCnt, MissCnt} !== '0)
      $display("FAIL reset_values: got we=%b v=%b rdy=%b idx=%0d tag=%h tgt=%h bc=%0d mc=%0d expected all zero",
               BtbWe, BtbWValid, Ready, BtbWIdx, BtbWTag, BtbWTarget, BranchCnt, MissCnt);
    else passes++;
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < ENTRY_NUM; k++) begin
      @(posedge clk); #1;
      checks++;
      if (BtbWe !== 1'b1 || BtbWIdx !== IDX_W'(k) || BtbWValid !== 1'b0 || Ready !== 1'b0)
        $display("FAIL sweep_cycle%0d: got we=%b idx=%0d v=%b rdy=%b expected we=1 idx=%0d v=0 rdy=0",
                 k, BtbWe, BtbWIdx, BtbWValid, Ready, k);
      else passes++;
    end
    @(posedge clk); #1;
    checks++;
    if (Ready !== 1'b1 || BtbWe !== 1'b0 || MispredictE !== 1'b0)
      $display("FAIL ready_after_sweep: got rdy=%b we=%b mp=%b expected rdy=1 we=0 mp=0",
               Ready, BtbWe, MispredictE);
    else passes++;
    m_run = 1;
  endtask

  task automatic test_alloc();
    logic [31:0] pc, npc;
    for (int i = 0; i < 5; i++) begin
      pc  = (i == 0) ? 32'h100 : ($urandom & 32'hFFFF_FFFC);
      npc = (i == 0) ? 32'h180 : ($urandom & 32'hFFFF_FFFC);
      apply_branch(1, BR_OP, pc, 0, 1, npc, 32'h0, '0, 0);
      checks++;
      if (MispredictE !== exp_mp || RedirectPC !== exp_rd)
        $display("FAIL alloc_flush%0d: got mp=%b rd=%h expected mp=%b rd=%h",
                 i, MispredictE, RedirectPC, exp_mp, exp_rd);
      else passes++;
      step();
      checks++;
      w = exp_q.pop_front();
      if (BtbWe !== 1'b1 || BtbWIdx !== w[WR_W-1 -: IDX_W] || BtbWTag !== w[64:33] ||
          BtbWTarget !== w[32:1] || BtbWValid !== w[0])
        $display("FAIL alloc_write%0d: got we=%b idx=%0d tag=%h tgt=%h v=%b expected we=1 idx=%0d tag=%h tgt=%h v=%b",
                 i, BtbWe, BtbWIdx, BtbWTag, BtbWTarget, BtbWValid,
                 w[WR_W-1 -: IDX_W], w[64:33], w[32:1], w[0]);
      else passes++;
    end
    checks++;
    if (BranchCnt !== m_branch || MissCnt !== m_miss)
      $display("FAIL alloc_counts: got bc=%0d mc=%0d expected bc=%0d mc=%0d",
               BranchCnt, MissCnt, m_branch, m_miss);
    else passes++;
  endtask

  task automatic test_retarget();
    logic [31:0] t_pc [2] = '{32'h200, 32'h208};
    logic        t_tk [2] = '{1'b0, 1'b1};
    logic [31:0] t_npc[2] = '{32'h1234, 32'h340};
    logic [31:0] t_ppc[2] = '{32'h280, 32'h300};
    for (int i = 0; i < 2; i++) begin
      apply_branch(1, BR_OP, t_pc[i], 1, t_tk[i], t_npc[i], t_ppc[i], IDX_W'(2), 0);
      checks++;
      if (MispredictE !== 1'b1 || RedirectPC !== exp_rd)
        $display("FAIL retarget_flush%0d: got mp=%b rd=%h expected mp=1 rd=%h",
                 i, MispredictE, RedirectPC, exp_rd);
      else passes++;
      step();
      checks++;
      w = exp_q.pop_front();
      if (BtbWe !== 1'b1 || BtbWIdx !== w[WR_W-1 -: IDX_W] || BtbWValid !== w[0] ||
          (w[0] && (BtbWTag !== w[64:33] || BtbWTarget !== w[32:1])))
        $display("FAIL retarget_write%0d: got we=%b idx=%0d tag=%h tgt=%h v=%b expected we=1 idx=%0d tag=%h tgt=%h v=%b",
                 i, BtbWe, BtbWIdx, BtbWTag, BtbWTarget, BtbWValid,
                 w[WR_W-1 -: IDX_W], w[64:33], w[32:1], w[0]);
      else passes++;
    end
  endtask

  task automatic test_correct();
    apply_branch(1, BR_OP, 32'h3F0, 1, 1, 32'h400, 32'h400, IDX_W'(1), 0);
    checks++;
    if (MispredictE !== 1'b0)
      $display("FAIL correct_taken_flush: got mp=%b expected 0", MispredictE);
    else passes++;
    step();
    checks++;
    if (BtbWe !== 1'b0 || BranchCnt !== m_branch || MissCnt !== m_miss)
      $display("FAIL correct_taken_state: got we=%b bc=%0d mc=%0d expected we=0 bc=%0d mc=%0d",
               BtbWe, BranchCnt, MissCnt, m_branch, m_miss);
    else passes++;
    apply_branch(0, BR_OP, 32'h500, 0, 1, 32'h580, 32'h0, '0, 0);
    checks++;
    if (MispredictE !== 1'b0 || RedirectPC !== 32'h0)
      $display("FAIL stalled_branch_flush: got mp=%b rd=%h expected mp=0 rd=0", MispredictE, RedirectPC);
    else passes++;
    step();
    checks++;
    if (BtbWe !== 1'b0 || BranchCnt !== m_branch || MissCnt !== m_miss)
      $display("FAIL stalled_branch_state: got we=%b bc=%0d mc=%0d expected we=0 bc=%0d mc=%0d",
               BtbWe, BranchCnt, MissCnt, m_branch, m_miss);
    else passes++;
  endtask

  task automatic test_random();
    logic        en, pred, taken;
    logic [6:0]  op;
    logic [31:0] pc, npc, ppc;
    for (int i = 0; i < 40; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      op    = ($urandom_range(0, 3) != 0) ? BR_OP : 7'($urandom);
      pred  = 1'($urandom_range(0, 1));
      taken = 1'($urandom_range(0, 1));
      pc    = $urandom & 32'hFFFF_FFFC;
      npc   = $urandom & 32'hFFFF_FFFC;
      ppc   = ($urandom_range(0, 1) != 0) ? npc : ($urandom & 32'hFFFF_FFFC);
      if (i == 39) pc = 32'hFFFF_FFFC;
      apply_branch(en, op, pc, pred, taken, npc, ppc, IDX_W'($urandom_range(0, ENTRY_NUM - 1)), 0);
      checks++;
      if (MispredictE !== exp_mp || ((exp_mp || !exp_res) && RedirectPC !== exp_rd))
        $display("FAIL random_flush%0d: got mp=%b rd=%h expected mp=%b rd=%h",
                 i, MispredictE, RedirectPC, exp_mp, exp_rd);
      else passes++;
      step();
      checks++;
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        if (BtbWe !== 1'b1 || BtbWIdx !== w[WR_W-1 -: IDX_W] || BtbWValid !== w[0] ||
            (w[0] && (BtbWTag !== w[64:33] || BtbWTarget !== w[32:1])))
          $display("FAIL random_write%0d: got we=%b idx=%0d tag=%h tgt=%h v=%b expected we=1 idx=%0d tag=%h tgt=%h v=%b",
                   i, BtbWe, BtbWIdx, BtbWTag, BtbWTarget, BtbWValid,
                   w[WR_W-1 -: IDX_W], w[64:33], w[32:1], w[0]);
        else passes++;
      end else if (BtbWe !== 1'b0)
        $display("FAIL random_nowrite%0d: got we=%b expected we=0", i, BtbWe);
      else passes++;
    end
    checks++;
    if (BranchCnt !== m_branch || MissCnt !== m_miss)
      $display("FAIL random_counts: got bc=%0d mc=%0d expected bc=%0d mc=%0d",
               BranchCnt, MissCnt, m_branch, m_miss);
    else passes++;
  endtask

  task automatic test_invalidate();
    apply_branch(1, BR_OP, 32'h500, 0, 1, 32'h580, 32'h0, '0, 1);
    checks++;
    if (MispredictE !== 1'b1 || RedirectPC !== 32'h580)
      $display("FAIL inval_flush: got mp=%b rd=%h expected mp=1 rd=00000580", MispredictE, RedirectPC);
    else passes++;
    step();
    m_run = 0;
    checks++;
    if (BtbWe !== 1'b0 || Ready !== 1'b0)
      $display("FAIL inval_drop: got we=%b rdy=%b expected we=0 rdy=0", BtbWe, Ready);
    else passes++;
    apply_branch(1, BR_OP, 32'h600, 1, 0, 32'h0, 32'h0, IDX_W'(3), 0);
    checks++;
    if (MispredictE !== 1'b1 || RedirectPC !== 32'h604)
      $display("FAIL init_flush: got mp=%b rd=%h expected mp=1 rd=00000604", MispredictE, RedirectPC);
    else passes++;
    step();
    checks++;
    if (BtbWe !== 1'b1 || BtbWIdx !== '0 || BtbWValid !== 1'b0 || BtbWTag !== 32'h0 ||
        BtbWTarget !== 32'h0 || BranchCnt !== m_branch || MissCnt !== m_miss)
      $display("FAIL init_sweep0: got we=%b idx=%0d v=%b tag=%h tgt=%h bc=%0d mc=%0d expected we=1 idx=0 v=0 tag=0 tgt=0 bc=%0d mc=%0d",
               BtbWe, BtbWIdx, BtbWValid, BtbWTag, BtbWTarget, BranchCnt, MissCnt, m_branch, m_miss);
    else passes++;
    repeat (ENTRY_NUM) @(posedge clk);
    #1;
    checks++;
    if (Ready !== 1'b1 || BtbWe !== 1'b0)
      $display("FAIL resweep_ready: got rdy=%b we=%b expected rdy=1 we=0", Ready, BtbWe);
    else passes++;
    m_run = 1;
    apply_branch(1, BR_OP, 32'h700, 0, 1, 32'h780, 32'h0, '0, 0);
    step();
    checks++;
    w = exp_q.pop_front();
    if (BtbWe !== 1'b1 || BtbWIdx !== w[WR_W-1 -: IDX_W] || BtbWTag !== 32'h700 || BtbWTarget !== 32'h780)
      $display("FAIL victim_kept: got we=%b idx=%0d tag=%h tgt=%h expected we=1 idx=%0d tag=00000700 tgt=00000780",
               BtbWe, BtbWIdx, BtbWTag, BtbWTarget, w[WR_W-1 -: IDX_W]);
    else passes++;
    apply_branch(0, 7'h0, 32'h0, 0, 0, 32'h0, 32'h0, '0, 1);
    step();
    m_run = 0;
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    checks++;
    if ({BtbWe, BtbWValid, Ready, BtbWIdx, BtbWTag, BtbWTarget, BranchCnt, MissCnt} !== '0)
      $display("FAIL midsweep_reset: got we=%b v=%b rdy=%b idx=%0d tag=%h tgt=%h bc=%0d mc=%0d expected all zero",
               BtbWe, BtbWValid, Ready, BtbWIdx, BtbWTag, BtbWTarget, BranchCnt, MissCnt);
    else passes++;
    m_branch = 0; m_miss = 0; m_victim = 0; exp_q.delete();
    @(negedge clk);
    rst = 0;
    repeat (ENTRY_NUM + 1) @(posedge clk);
    #1;
    m_run = 1;
    apply_branch(1, BR_OP, 32'h900, 0, 1, 32'h980, 32'h0, '0, 0);
    step();
    checks++;
    w = exp_q.pop_front();
    if (Ready !== 1'b1 || BtbWe !== 1'b1 || BtbWIdx !== w[WR_W-1 -: IDX_W] || BranchCnt !== m_branch)
      $display("FAIL victim_reset: got rdy=%b we=%b idx=%0d bc=%0d expected rdy=1 we=1 idx=%0d bc=%0d",
               Ready, BtbWe, BtbWIdx, BranchCnt, w[WR_W-1 -: IDX_W], m_branch);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_retarget();
    test_correct();
    test_random();
    test_invalidate();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
